// File: rtl/md_pkg.sv
// Shared constants, types and helpers for the MD byte packer slice.
package md_pkg;

    localparam int unsigned MD_DW = 32;
    localparam int unsigned MD_NB = MD_DW / 8;
    localparam int unsigned MD_OW = $clog2(MD_NB);
    localparam int unsigned MD_SW = $clog2(MD_NB) + 1;

    typedef logic [MD_OW-1:0] md_offset_t;
    typedef logic [MD_SW-1:0] md_size_t;

    typedef enum logic {IDLE, FLUSH_PEND} flush_state_e;

    // A transfer must carry at least one byte and must not run past the word end.
    function automatic logic md_legal(int unsigned offset, int unsigned size, int unsigned nb);
        return (size != 0) && (offset + size <= nb);
    endfunction

endpackage

// File: rtl/md_byte_extract.sv
// Right-aligns the valid bytes of an MD transfer and zeroes everything above size.
module md_byte_extract #(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB = DATA_WIDTH / 8,
    localparam int unsigned OW = $clog2(NB),
    localparam int unsigned SW = OW + 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [OW-1:0]         offset,
    input  logic [SW-1:0]         size,
    output logic [DATA_WIDTH-1:0] payload
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        payload = '0;
        for (int i = 0; i < NB; i++) begin
            payload[i*8 +: 8] = (SW'(i) < size) ? shifted[i*8 +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/md_byte_packer.sv
// Packs valid MD bytes contiguously into full words; flush emits a partial word with keep.
module md_byte_packer
    import md_pkg::*;
#(
    parameter int unsigned ALGN_DATA_WIDTH = MD_DW,
    localparam int unsigned W  = ALGN_DATA_WIDTH,
    localparam int unsigned NB = W / 8,
    localparam int unsigned OW = $clog2(NB),
    localparam int unsigned SW = OW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          md_valid,
    input  logic [W-1:0]  md_data,
    input  logic [OW-1:0] md_offset,
    input  logic [SW-1:0] md_size,
    output logic          md_ready,
    output logic          md_err,
    input  logic          flush,
    output logic          flush_busy,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [NB-1:0] out_keep,
    input  logic          out_ready,
    output logic [7:0]    err_cnt
);

    localparam logic [SW:0] NB_N = (SW+1)'(NB);

    flush_state_e  state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [NB-1:0] out_keep_q, out_keep_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [W-1:0]   payload;
    logic [2*W-1:0] merged;
    logic [SW:0]    n, n_rem;
    logic [NB-1:0]  flush_keep;
    logic           legal, stall, accept, flush_fire;

    md_byte_extract #(
        .DATA_WIDTH(W)
    ) u_extract (
        .data   (md_data),
        .offset (md_offset),
        .size   (md_size),
        .payload(payload)
    );

    assign legal    = md_legal(32'(md_offset), 32'(md_size), NB);
    assign stall    = out_valid_q && !out_ready;
    assign md_ready = !stall && !flush_busy;
    assign md_err   = md_valid && !legal;
    assign accept   = md_valid && md_ready;

    // acc bytes at and above cnt are always zero, so OR-ing in the new payload is enough.
    assign merged = acc_q | ({{W{1'b0}}, payload} << {cnt_q, 3'b000});
    assign n      = {1'b0, cnt_q} + {1'b0, md_size};
    assign n_rem  = n - NB_N;

    always_comb begin
        flush_keep = '0;
        for (int i = 0; i < NB; i++) begin
            flush_keep[i] = SW'(i) < cnt_q;
        end
    end

    // Flush FSM: state register / next state / outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (flush)  state_d = FLUSH_PEND;
            FLUSH_PEND: if (!stall) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (state_q == FLUSH_PEND);
        flush_fire = flush_busy && !stall;
    end

    // Accept and flush are exclusive: md_ready is low whenever a flush is pending.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            if (!legal) begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else if (n >= NB_N) begin
                out_valid_d = 1'b1;
                out_data_d  = merged[W-1:0];
                out_keep_d  = '1;
                acc_d       = merged >> W;
                cnt_d       = n_rem[SW-1:0];
            end else begin
                acc_d = merged;
                cnt_d = n[SW-1:0];
            end
        end else if (flush_fire && (cnt_q != '0)) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[W-1:0];
            out_keep_d  = flush_keep;
            acc_d       = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign err_cnt   = err_cnt_q;

endmodule
